// File: rtl/arith_pkg.sv
// Shared opcode map, FSM state encoding and opcode classification for the
// sequential arithmetic unit.
package arith_pkg;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_MUL     = 3'b001;
  localparam logic [2:0] OP_ABSDIFF = 3'b010;
  localparam logic [2:0] OP_DIV     = 3'b011;
  localparam logic [2:0] OP_INC     = 3'b100;
  localparam logic [2:0] OP_DEC     = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // mul and div iterate for W cycles; everything else finishes in one
  function automatic logic is_multi(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/arith_div_core.sv
// Restoring divider: one quotient bit per clock after load. The outputs show
// the partial quotient/remainder that the step in progress will produce.
module arith_div_core
  import arith_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] rem_q;
  logic [W-1:0] quo_q;
  logic [W-1:0] dvs_q;
  logic [W:0]   trial;
  logic [W-1:0] rem_sub;
  logic         ge;

  // trial < 2*divisor whenever divisor != 0, so the difference fits in W bits
  always_comb begin
    trial     = {rem_q, quo_q[W-1]};
    ge        = (trial >= {1'b0, dvs_q});
    rem_sub   = trial[W-1:0] - dvs_q;
    remainder = ge ? rem_sub : trial[W-1:0];
    quotient  = {quo_q[W-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else begin
      rem_q <= remainder;
      quo_q <= quotient;
    end
  end

endmodule

// File: rtl/arith_seq.sv
// Clocked arithmetic unit with start/done handshake: single-cycle add,
// absdiff, inc, dec; W-cycle shift-add multiply and restoring divide.
module arith_seq
  import arith_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2:0]     opcode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           dz,
  output logic           illegal
);

  localparam int CW = $clog2(W);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [2:0]     op_q;
  logic           dz_q;
  logic           accept;

  logic [2*W-1:0] acc_p0;
  logic [2*W-1:0] mcand_p0;
  logic [W-1:0]   mplier_p0;
  logic [2*W-1:0] acc_nxt;

  logic [W-1:0]   dvd;
  logic [W-1:0]   dvs;
  logic [W-1:0]   dvd_q;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;

  function automatic logic [2*W-1:0] single_op(input logic [2:0] op,
                                               input logic [W-1:0] x,
                                               input logic [W-1:0] y);
    logic [W:0]     sum;
    logic [W-1:0]   r;
    logic [2*W-1:0] res;
    sum = {1'b0, x} + {1'b0, y};
    r   = '0;
    res = '0;
    case (op)
      OP_ADD:     res = {{(W-1){1'b0}}, sum};
      OP_ABSDIFF: begin
        r   = (x >= y) ? (x - y) : (y - x);
        res = {{W{1'b0}}, r};
      end
      OP_INC: begin
        r   = x + 1'b1;
        res = {{W{1'b0}}, r};
      end
      OP_DEC: begin
        r   = x - 1'b1;
        res = {{W{1'b0}}, r};
      end
      default:    res = '0;
    endcase
    return res;
  endfunction

  assign accept = start && (state != CALC);
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

  // on a tie the dividend is b and the divisor a, which is the same value pair
  assign dvd = (a > b) ? a : b;
  assign dvs = (a > b) ? b : a;

  assign acc_nxt = mplier_p0[0] ? (acc_p0 + mcand_p0) : acc_p0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = is_multi(opcode) ? CALC : DONE;
        else        state_nxt = IDLE;
      end
      CALC:    if (cnt == '0) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= OP_ADD;
      dz_q    <= 1'b0;
      result  <= '0;
      dz      <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= opcode;
        cnt     <= CW'(W - 1);
        dz_q    <= (dvs == '0);
        dz      <= 1'b0;
        illegal <= 1'b0;
        if (!is_multi(opcode)) begin
          result  <= single_op(opcode, a, b);
          illegal <= opcode[2] & opcode[1];
        end
      end else if (state == CALC) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          if (op_q == OP_MUL) begin
            result <= acc_nxt;
          end else if (dz_q) begin
            result <= {dvd_q, {W{1'b1}}};
            dz     <= 1'b1;
          end else begin
            result <= {rem, quo};
          end
        end
      end
    end
  end

  // ---- iteration datapath: loaded at acceptance, advanced once per CALC cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_p0    <= '0;
      mcand_p0  <= {{W{1'b0}}, a};
      mplier_p0 <= b;
      dvd_q     <= dvd;
    end else if (state == CALC) begin
      acc_p0    <= acc_nxt;
      mcand_p0  <= {mcand_p0[2*W-2:0], 1'b0};
      mplier_p0 <= {1'b0, mplier_p0[W-1:1]};
    end
  end

  arith_div_core #(.W(W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept && (opcode == OP_DIV)),
    .dividend  (dvd),
    .divisor   (dvs),
    .quotient  (quo),
    .remainder (rem)
  );

endmodule
